// File: rtl/fmlarb_rr_pkg.sv
// Shared definitions for the 3-port round-robin FML arbiter.
package fmlarb_rr_pkg;

    // Number of requesting masters; fixed by construction of the picker.
    localparam int NPORTS = 3;
    // Width of a port index (0..2).
    localparam int IDX_W  = 2;
    // FML data and byte-select widths.
    localparam int FML_DW = 32;
    localparam int FML_SW = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Successor of a port index in round-robin order (wraps 2 -> 0).
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fmlarb_rr_pick.sv
// Combinational round-robin selector: searches last+1, last+2, last+3 (mod 3)
// and returns the first requesting port as one-hot grant and index.
module fmlarb_rr_pick
    import fmlarb_rr_pkg::*;
(
    input  logic [NPORTS-1:0] i_stb,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NPORTS-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    // Walk the candidates in priority order; the first requester wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = i_last;
        for (int k = 0; k < NPORTS; k++) begin
            cand = next_port(cand);
            if (!o_valid && i_stb[cand]) begin
                o_valid       = 1'b1;
                o_idx         = cand;
                o_grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmlarb_rr.sv
// Round-robin arbiter letting three FML masters share one FML slave.
// One IDLE cycle arbitrates and captures the winner's request; BUSY drives the
// slave from the captured copy until the slave acknowledges.
module fmlarb_rr
    import fmlarb_rr_pkg::*;
#(
    parameter  int fml_depth = 25,
    localparam int nports    = NPORTS
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,

    input  logic [nports*fml_depth-1:0] m_adr,
    input  logic [nports-1:0]           m_stb,
    input  logic [nports-1:0]           m_we,
    input  logic [nports*FML_SW-1:0]    m_sel,
    input  logic [nports*FML_DW-1:0]    m_do,
    output logic [nports-1:0]           m_ack,
    output logic [FML_DW-1:0]           m_di,

    output logic [fml_depth-1:0]        fml_adr,
    output logic                        fml_stb,
    output logic                        fml_we,
    output logic [FML_SW-1:0]           fml_sel,
    output logic [FML_DW-1:0]           fml_do,
    input  logic                        fml_ack,
    input  logic [FML_DW-1:0]           fml_di
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_load;
    logic                  w_busy;

    logic [nports-1:0]     r_grant;
    logic [IDX_W-1:0]      r_last;
    logic [fml_depth-1:0]  r_adr;
    logic                  r_we;
    logic [FML_SW-1:0]     r_sel;
    logic [FML_DW-1:0]     r_do;

    logic [nports-1:0]     w_pick_grant;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;

    logic [fml_depth-1:0]  w_port_adr [nports];
    logic [FML_SW-1:0]     w_port_sel [nports];
    logic [FML_DW-1:0]     w_port_do  [nports];

    // Unpack the per-master buses into indexable arrays.
    for (genvar gi = 0; gi < nports; gi++) begin : g_unpack
        assign w_port_adr[gi] = m_adr[gi*fml_depth +: fml_depth];
        assign w_port_sel[gi] = m_sel[gi*FML_SW +: FML_SW];
        assign w_port_do[gi]  = m_do[gi*FML_DW +: FML_DW];
    end

    fmlarb_rr_pick u_pick (
        .i_stb   (m_stb),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: arbitrate in IDLE, wait for the slave ack in BUSY.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = ST_BUSY;
                    w_load       = 1'b1;
                end
            end
            ST_BUSY: begin
                if (fml_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the winner's request and grant; drop the grant when the slave acks.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_grant <= '0;
            r_last  <= IDX_W'(nports - 1);
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_do    <= '0;
        end else if (w_load) begin
            r_grant <= w_pick_grant;
            r_last  <= w_pick_idx;
            r_adr   <= w_port_adr[w_pick_idx];
            r_we    <= m_we[w_pick_idx];
            r_sel   <= w_port_sel[w_pick_idx];
            r_do    <= w_port_do[w_pick_idx];
        end else if (w_busy && fml_ack) begin
            r_grant <= '0;
        end
    end

    // The slave only ever sees the captured copy, and nothing while IDLE.
    assign w_busy  = (r_state == ST_BUSY);
    assign fml_stb = w_busy;
    assign fml_adr = w_busy ? r_adr : '0;
    assign fml_we  = w_busy & r_we;
    assign fml_sel = w_busy ? r_sel : '0;
    assign fml_do  = w_busy ? r_do  : '0;

    // Ack goes only to the granted master; read data is broadcast.
    assign m_ack = (w_busy && fml_ack) ? r_grant : '0;
    assign m_di  = fml_di;

endmodule

// File: tb/tb_fmlarb_rr.sv
// Directed testbench for fmlarb_rr: one task per scenario, inline checks.
module tb_fmlarb_rr;

    localparam int DEPTH = 25;

    logic                sys_clk;
    logic                sys_rst;
    logic [3*DEPTH-1:0]  m_adr;
    logic [2:0]          m_stb;
    logic [2:0]          m_we;
    logic [11:0]         m_sel;
    logic [95:0]         m_do;
    logic [2:0]          m_ack;
    logic [31:0]         m_di;
    logic [DEPTH-1:0]    fml_adr;
    logic                fml_stb;
    logic                fml_we;
    logic [3:0]          fml_sel;
    logic [31:0]         fml_do;
    logic                fml_ack;
    logic [31:0]         fml_di;

    int vectors;
    int miscompares;

    fmlarb_rr #(.fml_depth(DEPTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_adr   (m_adr),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_do    (m_do),
        .m_ack   (m_ack),
        .m_di    (m_di),
        .fml_adr (fml_adr),
        .fml_stb (fml_stb),
        .fml_we  (fml_we),
        .fml_sel (fml_sel),
        .fml_do  (fml_do),
        .fml_ack (fml_ack),
        .fml_di  (fml_di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_sel   = '0;
        m_do    = '0;
        fml_ack = 1'b0;
        fml_di  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        sys_rst = 1'b1;
        step();
        vectors++;
        if (fml_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fml_stb: got %b expected 0", fml_stb);
        end
        vectors++;
        if (m_ack !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_m_ack: got %b expected 000", m_ack);
        end
        vectors++;
        if (fml_adr !== 25'h0 || fml_do !== 32'h0 || fml_sel !== 4'h0 || fml_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fml_bus: adr %h do %h sel %h we %b expected all 0",
                     fml_adr, fml_do, fml_sel, fml_we);
        end
        sys_rst = 1'b0;
        step();
        vectors++;
        if (fml_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_no_req: fml_stb %b expected 0", fml_stb);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        do_reset();
        m_stb            = 3'b001;
        m_adr[0 +: DEPTH] = 25'h0001000;
        m_we[0]          = 1'b0;
        m_sel[3:0]       = 4'hF;
        #1;
        vectors++;
        if (fml_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL read_stb_before_edge: got %b expected 0", fml_stb);
        end
        step();
        vectors++;
        if (fml_stb !== 1'b1 || fml_adr !== 25'h0001000 || fml_we !== 1'b0) begin
            miscompares++;
            $display("FAIL read_request: stb %b adr %h we %b expected 1 0001000 0",
                     fml_stb, fml_adr, fml_we);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (m_ack !== 3'b000 || fml_stb !== 1'b1) begin
                miscompares++;
                $display("FAIL read_wait%0d: m_ack %b fml_stb %b expected 000 1", i, m_ack, fml_stb);
            end
            step();
        end
        fml_ack = 1'b1;
        fml_di  = 32'hDEADBEEF;
        #1;
        vectors++;
        if (m_ack !== 3'b001 || m_di !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL read_ack: m_ack %b m_di %h expected 001 deadbeef", m_ack, m_di);
        end
        step();
        fml_ack = 1'b0;
        m_stb   = 3'b000;
        #1;
        vectors++;
        if (fml_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL read_back_idle: fml_stb %b expected 0", fml_stb);
        end
        $display("test_single_read done");
    endtask

    task automatic test_contention();
        logic [2:0] exp_order [6];
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        m_adr = {25'h0000300, 25'h0000200, 25'h0000100};
        m_stb = 3'b111;
        for (int g = 0; g < 6; g++) begin
            step();
            fml_ack = 1'b1;
            #1;
            vectors++;
            if (m_ack !== exp_order[g] || $countones(m_ack) > 1) begin
                miscompares++;
                $display("FAIL contention_grant%0d: m_ack %b expected %b", g, m_ack, exp_order[g]);
            end
            step();
            fml_ack = 1'b0;
            #1;
            vectors++;
            if (fml_stb !== 1'b0 || m_ack !== 3'b000) begin
                miscompares++;
                $display("FAIL contention_gap%0d: fml_stb %b m_ack %b expected 0 000", g, fml_stb, m_ack);
            end
        end
        m_stb = 3'b000;
        step();
        $display("test_contention done");
    endtask

    task automatic test_capture();
        do_reset();
        m_stb                 = 3'b010;
        m_we[1]               = 1'b1;
        m_sel[4 +: 4]         = 4'hF;
        m_do[32 +: 32]        = 32'h12345678;
        m_adr[DEPTH +: DEPTH] = 25'h0ABCDE0;
        step();
        m_do  = '0;
        m_sel = '0;
        m_we  = '0;
        m_adr = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (fml_do !== 32'h12345678 || fml_sel !== 4'hF || fml_we !== 1'b1 ||
                fml_adr !== 25'h0ABCDE0) begin
                miscompares++;
                $display("FAIL capture_hold%0d: do %h sel %h we %b adr %h expected 12345678 f 1 0abcde0",
                         i, fml_do, fml_sel, fml_we, fml_adr);
            end
            step();
        end
        fml_ack = 1'b1;
        #1;
        vectors++;
        if (m_ack !== 3'b010 || fml_do !== 32'h12345678) begin
            miscompares++;
            $display("FAIL capture_ack: m_ack %b do %h expected 010 12345678", m_ack, fml_do);
        end
        step();
        fml_ack = 1'b0;
        m_stb   = 3'b000;
        step();
        $display("test_capture done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_stb = 3'b001;
        step();
        vectors++;
        if (fml_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy: fml_stb %b expected 1", fml_stb);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (fml_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async: fml_stb %b expected 0", fml_stb);
        end
        step();
        sys_rst = 1'b0;
        m_stb   = 3'b110;
        m_adr[DEPTH +: DEPTH] = 25'h0000111;
        m_adr[2*DEPTH +: DEPTH] = 25'h0000222;
        #1;
        step();
        fml_ack = 1'b1;
        #1;
        vectors++;
        if (m_ack !== 3'b010 || fml_adr !== 25'h0000111) begin
            miscompares++;
            $display("FAIL rstmid_regrant: m_ack %b adr %h expected 010 0000111", m_ack, fml_adr);
        end
        step();
        fml_ack = 1'b0;
        m_stb   = 3'b000;
        step();
        $display("test_reset_mid done");
    endtask

    task automatic test_spurious_ack();
        do_reset();
        fml_ack = 1'b1;
        #1;
        vectors++;
        if (m_ack !== 3'b000) begin
            miscompares++;
            $display("FAIL spurious_ack: m_ack %b expected 000", m_ack);
        end
        step();
        vectors++;
        if (fml_stb !== 1'b0 || m_ack !== 3'b000) begin
            miscompares++;
            $display("FAIL spurious_state: fml_stb %b m_ack %b expected 0 000", fml_stb, m_ack);
        end
        fml_ack = 1'b0;
        step();
        $display("test_spurious_ack done");
    endtask

    task automatic test_fairness();
        logic [2:0] exp_order [3];
        int         budget;
        exp_order = '{3'b001, 3'b100, 3'b001};
        do_reset();
        m_stb = 3'b001;
        for (int g = 0; g < 3; g++) begin
            // Wait (bounded) for the arbiter to grant someone.
            budget = 0;
            step();
            while (fml_stb !== 1'b1 && budget < 10) begin
                step();
                budget++;
            end
            if (g == 0) begin
                m_stb[2] = 1'b1;   // port 2 requests while port 0 is being served
            end
            fml_ack = 1'b1;
            #1;
            vectors++;
            if (m_ack !== exp_order[g]) begin
                miscompares++;
                $display("FAIL fairness_grant%0d: m_ack %b expected %b", g, m_ack, exp_order[g]);
            end
            if (m_ack[2] === 1'b1) begin
                m_stb[2] = 1'b0;   // port 2 was served once; it drops after ack
            end
            step();
            fml_ack = 1'b0;
        end
        m_stb = 3'b000;
        step();
        $display("test_fairness done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_capture();
        test_reset_mid();
        test_spurious_ack();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
